// File: rtl/regfile_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_writeback_arbiter
//
// Drives the register file's single write port from two producers:
//   - the in-order pipeline writeback stage (no backpressure, always wins)
//   - a long-latency unit (mul/div) behind a valid/ready handshake, whose
//     results wait in a small FIFO until a cycle with no pipeline write.
// All write-port outputs are registered; the register file samples them on
// the next rising edge.
//
// Ports:
//   clk, resetN                    clock, asynchronous active-low reset
//   pipeValid/pipeIndex/pipeData   pipeline writeback result
//   longValid/longIndex/longData   long-latency result offer
//   longReady                      long-latency result accepted (FIFO not full)
//   writeRegisterIndex/Data        register file write index / data
//   shouldWrite                    register file write enable
//   pendingCount                   queued long-latency results not yet written
//   pipeStall                      FIFO full; upstream holds new long issue
//
// Optional feature (macro WB_FORWARD_EN):
//   lookupIndexA/B -> lookupHitA/B, lookupDataA/B: combinational search of
//   the output register and all queued entries, youngest match wins.
//   Index 0 never hits. Without the macro these ports do not exist and
//   consumers stall on pendingCount != 0.
// ---------------------------------------------------------------------------
module regfile_writeback_arbiter #(
    parameter int FIFO_DEPTH  = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic                          pipeValid,
    input  logic [INDEX_WIDTH-1:0]        pipeIndex,
    input  logic [DATA_WIDTH-1:0]         pipeData,
    input  logic                          longValid,
    output logic                          longReady,
    input  logic [INDEX_WIDTH-1:0]        longIndex,
    input  logic [DATA_WIDTH-1:0]         longData,
    output logic [INDEX_WIDTH-1:0]        writeRegisterIndex,
    output logic [DATA_WIDTH-1:0]         writeRegisterData,
    output logic                          shouldWrite,
    output logic [$clog2(FIFO_DEPTH):0]   pendingCount,
    output logic                          pipeStall
`ifdef WB_FORWARD_EN
    ,
    input  logic [INDEX_WIDTH-1:0]        lookupIndexA,
    input  logic [INDEX_WIDTH-1:0]        lookupIndexB,
    output logic                          lookupHitA,
    output logic                          lookupHitB,
    output logic [DATA_WIDTH-1:0]         lookupDataA,
    output logic [DATA_WIDTH-1:0]         lookupDataB
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [INDEX_WIDTH-1:0] fifoIndex [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]  fifoData  [FIFO_DEPTH];
    logic [PTR_W-1:0]       headPtr;
    logic [PTR_W-1:0]       tailPtr;

    logic fifoFull;
    logic fifoEmpty;
    logic pipeWins;
    logic doPop;
    logic doPush;

    // Full/empty come from the registered occupancy only, so longReady never
    // depends on this cycle's pop: a full FIFO refuses a push even while it
    // is draining.
    assign fifoFull  = (pendingCount == CNT_W'(FIFO_DEPTH));
    assign fifoEmpty = (pendingCount == '0);
    assign longReady = !fifoFull;
    assign pipeStall = fifoFull;

    // A pipeline write to x0 is not a write, which lets the FIFO drain.
    assign pipeWins = pipeValid && (pipeIndex != '0);
    assign doPop    = !pipeWins && !fifoEmpty;
    // x0 results complete the handshake but are never queued.
    assign doPush   = longValid && longReady && (longIndex != '0);

    // NOTE: the queue storage has no reset; occupancy is tracked by the
    // pointers and count, so stale contents are never observed and the
    // array can map to plain RAM/flops without reset wiring.
    always_ff @(posedge clk) begin
        if (doPush) begin
            fifoIndex[tailPtr] <= longIndex;
            fifoData[tailPtr]  <= longData;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register sees the pre-edge values of the others regardless of order.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            headPtr            <= '0;
            tailPtr            <= '0;
            pendingCount       <= '0;
            shouldWrite        <= 1'b0;
            writeRegisterIndex <= '0;
            writeRegisterData  <= '0;
        end else begin
            // Pointers wrap naturally because FIFO_DEPTH is a power of two.
            if (doPush) tailPtr <= tailPtr + PTR_W'(1);
            if (doPop)  headPtr <= headPtr + PTR_W'(1);
            pendingCount <= pendingCount + CNT_W'(doPush) - CNT_W'(doPop);

            if (pipeWins) begin
                shouldWrite        <= 1'b1;
                writeRegisterIndex <= pipeIndex;
                writeRegisterData  <= pipeData;
            end else if (doPop) begin
                shouldWrite        <= 1'b1;
                writeRegisterIndex <= fifoIndex[headPtr];
                writeRegisterData  <= fifoData[headPtr];
            end else begin
                // Index/data hold so the port only toggles on real writes.
                shouldWrite <= 1'b0;
            end
        end
    end

`ifdef WB_FORWARD_EN
    // Search from oldest to youngest so a later match overwrites an earlier
    // one: output register first, then FIFO head towards tail.
    function automatic logic [DATA_WIDTH:0] searchYoungest(
        input logic [INDEX_WIDTH-1:0] idx
    );
        logic                  hit;
        logic [DATA_WIDTH-1:0] data;
        logic [PTR_W-1:0]      slot;
        hit  = 1'b0;
        data = '0;
        slot = '0;
        if (idx != '0) begin
            if (shouldWrite && (writeRegisterIndex == idx)) begin
                hit  = 1'b1;
                data = writeRegisterData;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                slot = headPtr + PTR_W'(i);
                if ((CNT_W'(i) < pendingCount) && (fifoIndex[slot] == idx)) begin
                    hit  = 1'b1;
                    data = fifoData[slot];
                end
            end
        end
        return {hit, data};
    endfunction

    // NOTE: combinational outputs are assigned on every path (here in one
    // concatenated assignment per port) so no latch can be inferred.
    always_comb begin
        {lookupHitA, lookupDataA} = searchYoungest(lookupIndexA);
        {lookupHitB, lookupDataB} = searchYoungest(lookupIndexB);
    end
`endif

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_writeback_arbiter
//
// Self-checking bench for regfile_writeback_arbiter (default parameters).
// A queue-based reference model predicts the write port and occupancy every
// cycle; a vector table and hand-written sequences add fixed expectations
// for the pipeline path, long path, contention, push/pop, wrap and reset.
// The lookup ports are exercised when WB_FORWARD_EN is defined.
// ---------------------------------------------------------------------------
module tb_regfile_writeback_arbiter;

    localparam int DEPTH = 4;

    logic        clk;
    logic        resetN;
    logic        pipeValid;
    logic [4:0]  pipeIndex;
    logic [31:0] pipeData;
    logic        longValid;
    logic        longReady;
    logic [4:0]  longIndex;
    logic [31:0] longData;
    logic [4:0]  writeRegisterIndex;
    logic [31:0] writeRegisterData;
    logic        shouldWrite;
    logic [2:0]  pendingCount;
    logic        pipeStall;
`ifdef WB_FORWARD_EN
    logic [4:0]  lookupIndexA;
    logic [4:0]  lookupIndexB;
    logic        lookupHitA;
    logic        lookupHitB;
    logic [31:0] lookupDataA;
    logic [31:0] lookupDataB;
`endif

    regfile_writeback_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .DATA_WIDTH (32),
        .INDEX_WIDTH(5)
    ) dut (
        .clk               (clk),
        .resetN            (resetN),
        .pipeValid         (pipeValid),
        .pipeIndex         (pipeIndex),
        .pipeData          (pipeData),
        .longValid         (longValid),
        .longReady         (longReady),
        .longIndex         (longIndex),
        .longData          (longData),
        .writeRegisterIndex(writeRegisterIndex),
        .writeRegisterData (writeRegisterData),
        .shouldWrite       (shouldWrite),
        .pendingCount      (pendingCount),
        .pipeStall         (pipeStall)
`ifdef WB_FORWARD_EN
        ,
        .lookupIndexA      (lookupIndexA),
        .lookupIndexB      (lookupIndexB),
        .lookupHitA        (lookupHitA),
        .lookupHitB        (lookupHitB),
        .lookupDataA       (lookupDataA),
        .lookupDataB       (lookupDataB)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: a queue of pending results plus the expected port.
    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } entry_t;

    entry_t      modelQ[$];
    logic        expShould;
    logic [4:0]  expIdx;
    logic [31:0] expData;

    // One table row is one clock: inputs, then the port state after the edge.
    typedef struct packed {
        logic        pV;
        logic [4:0]  pI;
        logic [31:0] pD;
        logic        lV;
        logic [4:0]  lI;
        logic [31:0] lD;
        logic        eShould;
        logic [4:0]  eIdx;
        logic [31:0] eData;
        logic [2:0]  ePend;
        logic        eReady;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        modelQ.delete();
        expShould = 1'b0;
        expIdx    = '0;
        expData   = '0;
    endtask

    task automatic checkModel(input string tag);
        check({tag, ".shouldWrite"}, 32'(shouldWrite), 32'(expShould));
        check({tag, ".index"},       32'(writeRegisterIndex), 32'(expIdx));
        check({tag, ".data"},        writeRegisterData, expData);
        check({tag, ".pending"},     32'(pendingCount), 32'(modelQ.size()));
        check({tag, ".longReady"},   32'(longReady), 32'(modelQ.size() < DEPTH));
        check({tag, ".pipeStall"},   32'(pipeStall), 32'(modelQ.size() == DEPTH));
    endtask

    // Advance one clock with the currently driven inputs, update the model
    // from the arbitration rules, and compare just after the edge.
    task automatic step(input string tag);
        bit     ready;
        bit     pipeWrite;
        entry_t head;
        entry_t incoming;
        ready     = (modelQ.size() < DEPTH);
        pipeWrite = pipeValid && (pipeIndex != 0);
        if (pipeWrite) begin
            expShould = 1'b1;
            expIdx    = pipeIndex;
            expData   = pipeData;
        end else if (modelQ.size() > 0) begin
            head      = modelQ.pop_front();
            expShould = 1'b1;
            expIdx    = head.idx;
            expData   = head.data;
        end else begin
            expShould = 1'b0;
        end
        if (longValid && ready && (longIndex != 0)) begin
            incoming.idx  = longIndex;
            incoming.data = longData;
            modelQ.push_back(incoming);
        end
        @(posedge clk);
        #1;
        checkModel(tag);
    endtask

    task automatic drive(input logic pV, input logic [4:0] pI, input logic [31:0] pD,
                         input logic lV, input logic [4:0] lI, input logic [31:0] lD);
        pipeValid = pV;
        pipeIndex = pI;
        pipeData  = pD;
        longValid = lV;
        longIndex = lI;
        longData  = lD;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    initial begin
        resetN = 1'b0;
        idle();
`ifdef WB_FORWARD_EN
        lookupIndexA = '0;
        lookupIndexB = '0;
`endif
        modelReset();

        // ---------------- reset state ----------------
        #12;
        check("reset.shouldWrite", 32'(shouldWrite), 32'd0);
        check("reset.index",       32'(writeRegisterIndex), 32'd0);
        check("reset.data",        writeRegisterData, 32'd0);
        check("reset.pending",     32'(pendingCount), 32'd0);
        check("reset.pipeStall",   32'(pipeStall), 32'd0);
        resetN = 1'b1;
        #1;
        check("reset.longReady",   32'(longReady), 32'd1);

        // ---------------- vector table ----------------
        //        pV  pI     pD            lV  lI     lD       eS  eI     eD            eP    eR
        vecs[0] = '{1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 32'hDEADBEEF, 3'd0, 1'b1};
        vecs[1] = '{1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 32'h0,  1'b0, 5'd7, 32'hDEADBEEF, 3'd0, 1'b1};
        vecs[2] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h55, 1'b0, 5'd7, 32'hDEADBEEF, 3'd1, 1'b1};
        vecs[3] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 32'h55,       3'd0, 1'b1};
        vecs[4] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h99, 1'b0, 5'd3, 32'h55,       3'd0, 1'b1};
        vecs[5] = '{1'b1, 5'd9, 32'hA,        1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'hA,        3'd1, 1'b1};
        vecs[6] = '{1'b1, 5'd0, 32'hB,        1'b0, 5'd0, 32'h0,  1'b1, 5'd4, 32'h44,       3'd0, 1'b1};
        vecs[7] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd4, 32'h44,       3'd0, 1'b1};

        for (int v = 0; v < 8; v++) begin
            drive(vecs[v].pV, vecs[v].pI, vecs[v].pD, vecs[v].lV, vecs[v].lI, vecs[v].lD);
            step($sformatf("vec%0d.model", v));
            check($sformatf("vec%0d.shouldWrite", v), 32'(shouldWrite), 32'(vecs[v].eShould));
            check($sformatf("vec%0d.index", v), 32'(writeRegisterIndex), 32'(vecs[v].eIdx));
            check($sformatf("vec%0d.data", v), writeRegisterData, vecs[v].eData);
            check($sformatf("vec%0d.pending", v), 32'(pendingCount), 32'(vecs[v].ePend));
            check($sformatf("vec%0d.longReady", v), 32'(longReady), 32'(vecs[v].eReady));
        end

        // ---------------- contention: pipeline holds reg 9 for 6 cycles ----------------
        for (int c = 1; c <= 6; c++) begin
            if (c <= 4)
                drive(1'b1, 5'd9, 32'h900 + 32'(c), 1'b1, 5'(9 + c), 32'd99 + 32'(c));
            else if (c == 5)
                drive(1'b1, 5'd9, 32'h900 + 32'(c), 1'b1, 5'd14, 32'd200);
            else
                drive(1'b1, 5'd9, 32'h900 + 32'(c), 1'b0, 5'd0, 32'h0);
            step($sformatf("cont%0d.model", c));
            check($sformatf("cont%0d.shouldWrite", c), 32'(shouldWrite), 32'd1);
            check($sformatf("cont%0d.index", c), 32'(writeRegisterIndex), 32'd9);
            check($sformatf("cont%0d.data", c), writeRegisterData, 32'h900 + 32'(c));
            if (c >= 4) begin
                check($sformatf("cont%0d.pending", c), 32'(pendingCount), 32'd4);
                check($sformatf("cont%0d.longReady", c), 32'(longReady), 32'd0);
                check($sformatf("cont%0d.pipeStall", c), 32'(pipeStall), 32'd1);
            end
        end
        for (int k = 0; k < 4; k++) begin
            // The first drain cycle also offers a result while still full.
            if (k == 0) drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd15, 32'd300);
            else        idle();
            step($sformatf("drain%0d.model", k));
            check($sformatf("drain%0d.shouldWrite", k), 32'(shouldWrite), 32'd1);
            check($sformatf("drain%0d.index", k), 32'(writeRegisterIndex), 32'(10 + k));
            check($sformatf("drain%0d.data", k), writeRegisterData, 32'(100 + k));
            check($sformatf("drain%0d.pending", k), 32'(pendingCount), 32'(3 - k));
        end

        // ---------------- simultaneous push and pop at count 2 ----------------
        drive(1'b1, 5'd20, 32'h2001, 1'b1, 5'd21, 32'h21);
        step("pp1");
        drive(1'b1, 5'd20, 32'h2002, 1'b1, 5'd22, 32'h22);
        step("pp2");
        check("pp2.pending", 32'(pendingCount), 32'd2);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd23, 32'h23);
        step("pp3");
        check("pp3.pending", 32'(pendingCount), 32'd2);
        check("pp3.index", 32'(writeRegisterIndex), 32'd21);
        check("pp3.data", writeRegisterData, 32'h21);
        idle();
        step("pp4");
        check("pp4.index", 32'(writeRegisterIndex), 32'd22);
        step("pp5");
        check("pp5.index", 32'(writeRegisterIndex), 32'd23);
        check("pp5.data", writeRegisterData, 32'h23);
        check("pp5.pending", 32'(pendingCount), 32'd0);
        step("pp6");

        // ---------------- pointer wrap: 10 back-to-back pushes ----------------
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(1 + k), 32'h1000 + 32'(k));
            step($sformatf("wrap%0d.model", k));
            check($sformatf("wrap%0d.pending", k), 32'(pendingCount), 32'd1);
            if (k >= 1) begin
                check($sformatf("wrap%0d.index", k), 32'(writeRegisterIndex), 32'(k));
                check($sformatf("wrap%0d.data", k), writeRegisterData, 32'h1000 + 32'(k - 1));
            end
        end
        idle();
        step("wrapEnd");
        check("wrapEnd.index", 32'(writeRegisterIndex), 32'd10);
        check("wrapEnd.data", writeRegisterData, 32'h1009);
        step("wrapIdle");

        // ---------------- reset mid-run with 3 queued ----------------
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'd20, 32'h3000 + 32'(k), 1'b1, 5'(24 + k), 32'h2400 + 32'(k));
            step($sformatf("rst%0d.model", k));
        end
        check("rstPre.pending", 32'(pendingCount), 32'd3);
        idle();
        resetN = 1'b0;
        #2;
        modelReset();
        check("rstMid.shouldWrite", 32'(shouldWrite), 32'd0);
        check("rstMid.pending", 32'(pendingCount), 32'd0);
        check("rstMid.index", 32'(writeRegisterIndex), 32'd0);
        check("rstMid.data", writeRegisterData, 32'd0);
        #3;
        resetN = 1'b1;
        #1;
        check("rstRel.longReady", 32'(longReady), 32'd1);
        check("rstRel.pipeStall", 32'(pipeStall), 32'd0);
        for (int k = 0; k < 5; k++) begin
            step($sformatf("rstAfter%0d.model", k));
            check($sformatf("rstAfter%0d.shouldWrite", k), 32'(shouldWrite), 32'd0);
        end

        // ---------------- randomized traffic vs reference model ----------------
        for (int n = 0; n < 1500; n++) begin
            drive(($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
                  5'($urandom_range(0, 31)), $urandom,
                  ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                  5'($urandom_range(0, 31)), $urandom);
            step($sformatf("rand%0d", n));
        end
        idle();
        for (int k = 0; k < 6; k++) step($sformatf("randDrain%0d", k));

`ifdef WB_FORWARD_EN
        // ---------------- forwarding lookup ----------------
        drive(1'b1, 5'd20, 32'hAA, 1'b1, 5'd5, 32'h1);
        step("fwd1");
        drive(1'b1, 5'd20, 32'hBB, 1'b1, 5'd5, 32'h2);
        step("fwd2");
        idle();
        lookupIndexA = 5'd5;
        lookupIndexB = 5'd0;
        #1;
        check("fwd.hitA", 32'(lookupHitA), 32'd1);
        check("fwd.dataA", lookupDataA, 32'h2);
        check("fwd.hitB", 32'(lookupHitB), 32'd0);
        lookupIndexB = 5'd20;
        #1;
        check("fwd.hitOutReg", 32'(lookupHitB), 32'd1);
        check("fwd.dataOutReg", lookupDataB, 32'hBB);
        lookupIndexA = '0;
        lookupIndexB = '0;
        for (int k = 0; k < 3; k++) step($sformatf("fwdDrain%0d", k));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
